// File: rtl/param_updown_counter_if.sv
// Control/status bundle for param_updown_counter. The UpDown member exists only
// when COUNTER_UPDOWN_EN is defined.
interface param_updown_counter_if #(
    parameter int WIDTH = 13
);
    logic             Enable;
    logic             Clear;
    logic             Load;
    logic [WIDTH-1:0] LoadValue;
`ifdef COUNTER_UPDOWN_EN
    logic             UpDown;
`endif
    logic [WIDTH-1:0] S;
    logic             Tick;
    logic             TerminalCount;
    logic             Overflow;

`ifdef COUNTER_UPDOWN_EN
    modport master (output Enable, Clear, Load, LoadValue, UpDown,
                    input  S, Tick, TerminalCount, Overflow);
    modport slave  (input  Enable, Clear, Load, LoadValue, UpDown,
                    output S, Tick, TerminalCount, Overflow);
`else
    modport master (output Enable, Clear, Load, LoadValue,
                    input  S, Tick, TerminalCount, Overflow);
    modport slave  (input  Enable, Clear, Load, LoadValue,
                    output S, Tick, TerminalCount, Overflow);
`endif
endinterface

// File: rtl/param_updown_counter.sv
// Prescaled wrap/saturate counter with load, clear and sticky overflow.
// Define COUNTER_UPDOWN_EN to add the UpDown direction input (up-only otherwise).
module param_updown_counter #(
    parameter int WIDTH    = 13,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic                  Clock,
    input  logic                  ResetN,
    param_updown_counter_if.slave bus
);
    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    prescale_q, prescale_d;
    logic             overflow_q, overflow_d;

    logic             dir_up;
    logic             tick;
    logic             at_end;
    logic [WIDTH-1:0] end_value;
    logic [WIDTH-1:0] wrap_value;
    logic [WIDTH-1:0] stepped;

`ifdef COUNTER_UPDOWN_EN
    assign dir_up = bus.UpDown;
`else
    assign dir_up = 1'b1;
`endif

    // End value and its wrap target both depend on the direction of this edge.
    assign end_value  = dir_up ? CNT_MAX  : CNT_ZERO;
    assign wrap_value = dir_up ? CNT_ZERO : CNT_MAX;
    assign stepped    = dir_up ? (count_q + CNT_ONE) : (count_q - CNT_ONE);

    assign tick   = bus.Enable & (prescale_q == PRE_LAST);
    assign at_end = (count_q == end_value);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        count_d    = count_q;
        prescale_d = prescale_q;
        overflow_d = overflow_q;

        if (bus.Clear) begin
            count_d    = CNT_ZERO;
            prescale_d = '0;
            overflow_d = 1'b0;
        end else if (bus.Load) begin
            count_d    = bus.LoadValue;
            prescale_d = '0;
        end else if (bus.Enable) begin
            prescale_d = tick ? '0 : (prescale_q + PRE_ONE);
            if (tick) begin
                if (at_end) begin
                    overflow_d = 1'b1;
                    count_d    = (SATURATE != 0) ? count_q : wrap_value;
                end else begin
                    count_d    = stepped;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (!ResetN) begin
            count_q    <= CNT_ZERO;
            prescale_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            prescale_q <= prescale_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.S             = count_q;
    assign bus.Tick          = tick;
    assign bus.TerminalCount = at_end;
    assign bus.Overflow      = overflow_q;
endmodule

// File: tb/tb_param_updown_counter.sv
// Three WIDTH=4 counters (prescale-3 wrap, prescale-1 wrap, prescale-1 saturate)
// driven by one stimulus stream and compared against an arithmetic model.
module tb_param_updown_counter;
    localparam int N      = 3;
    localparam int W      = 4;
    localparam int MAXV   = 15;
    localparam int PS[N]  = '{3, 1, 1};
    localparam int SAT[N] = '{0, 0, 1};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    param_updown_counter_if #(.WIDTH(W)) if_a ();
    param_updown_counter_if #(.WIDTH(W)) if_b ();
    param_updown_counter_if #(.WIDTH(W)) if_c ();

    param_updown_counter #(.WIDTH(W), .PRESCALE(3), .SATURATE(0)) u_a (
        .Clock(clk), .ResetN(rst_n), .bus(if_a));
    param_updown_counter #(.WIDTH(W), .PRESCALE(1), .SATURATE(0)) u_b (
        .Clock(clk), .ResetN(rst_n), .bus(if_b));
    param_updown_counter #(.WIDTH(W), .PRESCALE(1), .SATURATE(1)) u_c (
        .Clock(clk), .ResetN(rst_n), .bus(if_c));

    logic         en, clr, ld, dir;
    logic [W-1:0] lv;

    assign if_a.Enable = en;  assign if_b.Enable = en;  assign if_c.Enable = en;
    assign if_a.Clear  = clr; assign if_b.Clear  = clr; assign if_c.Clear  = clr;
    assign if_a.Load   = ld;  assign if_b.Load   = ld;  assign if_c.Load   = ld;
    assign if_a.LoadValue = lv; assign if_b.LoadValue = lv; assign if_c.LoadValue = lv;
`ifdef COUNTER_UPDOWN_EN
    assign if_a.UpDown = dir; assign if_b.UpDown = dir; assign if_c.UpDown = dir;
`endif

    logic [W-1:0] s_o [N];
    logic         tick_o [N], tc_o [N], ov_o [N];
    assign s_o[0] = if_a.S;  assign tick_o[0] = if_a.Tick;
    assign tc_o[0] = if_a.TerminalCount; assign ov_o[0] = if_a.Overflow;
    assign s_o[1] = if_b.S;  assign tick_o[1] = if_b.Tick;
    assign tc_o[1] = if_b.TerminalCount; assign ov_o[1] = if_b.Overflow;
    assign s_o[2] = if_c.S;  assign tick_o[2] = if_c.Tick;
    assign tc_o[2] = if_c.TerminalCount; assign ov_o[2] = if_c.Overflow;

    // Model state: count value, enabled cycles into the current prescale period, overflow.
    int m_s [N];
    int m_n [N];
    bit m_ov[N];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_tick(input int i);
        return en && ((m_n[i] % PS[i]) == PS[i] - 1);
    endfunction

    function automatic int end_val();
        return dir ? MAXV : 0;
    endfunction

    // One clock: apply inputs at the falling edge, check, then advance the model.
    task automatic cycle(input bit r, input bit e, input bit c, input bit l,
                         input int v, input bit u);
        @(negedge clk);
        rst_n = r; en = e; clr = c; ld = l; lv = W'(v);
`ifdef COUNTER_UPDOWN_EN
        dir = u;
`else
        dir = 1'b1 | u;
`endif
        #1;
        for (int i = 0; i < N; i++) begin
            check($sformatf("S[%0d]", i),    32'(s_o[i]),    32'(m_s[i]));
            check($sformatf("OV[%0d]", i),   32'(ov_o[i]),   32'(m_ov[i]));
            check($sformatf("TICK[%0d]", i), 32'(tick_o[i]), 32'(model_tick(i)));
            check($sformatf("TC[%0d]", i),   32'(tc_o[i]),   32'(m_s[i] == end_val()));
        end
        for (int i = 0; i < N; i++) begin
            if (!r || c) begin
                m_s[i] = 0; m_n[i] = 0; m_ov[i] = 1'b0;
            end else if (l) begin
                m_s[i] = v; m_n[i] = 0;
            end else if (e) begin
                bit tk;
                tk = model_tick(i);
                m_n[i] = (m_n[i] + 1) % PS[i];
                if (tk) begin
                    if (m_s[i] == end_val()) m_ov[i] = 1'b1;
                    if (!(SAT[i] != 0 && m_s[i] == end_val()))
                        m_s[i] = (m_s[i] + (dir ? 1 : MAXV)) % (MAXV + 1);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; ld = 1'b0; lv = '0; dir = 1'b1;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            m_s[i] = 0; m_n[i] = 0; m_ov[i] = 1'b0;
        end

        // Reset from a non-zero count.
        cycle(1, 0, 0, 1, 9, 1);
        cycle(0, 1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);

        // Nine enabled clocks from zero.
        for (int k = 0; k < 9; k++) cycle(1, 1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);

        // Load 14 then count through the wrap / saturate end.
        cycle(1, 0, 0, 1, 14, 1);
        for (int k = 0; k < 4; k++) cycle(1, 1, 0, 0, 0, 1);
        cycle(1, 0, 1, 0, 0, 1);

        // Clear beats Load; Load beats a pending Tick.
        cycle(1, 1, 1, 1, 7, 1);
        cycle(1, 1, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 0, 1);
        cycle(1, 1, 0, 1, 7, 1);
        cycle(1, 1, 0, 0, 0, 1);

        // Enable dropped mid-prescale, then resumed.
        cycle(1, 0, 0, 0, 0, 1);
        cycle(1, 1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) cycle(1, 1, 0, 0, 0, 1);

        // Down count through zero (meaningful only with the direction input).
        cycle(1, 0, 1, 0, 0, 0);
        cycle(1, 0, 0, 1, 1, 0);
        for (int k = 0; k < 4; k++) cycle(1, 1, 0, 0, 0, 0);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 49) != 0),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 24) == 0),
                  ($urandom_range(0, 11) == 0),
                  int'($urandom_range(0, MAXV)),
                  ($urandom_range(0, 1) == 1));
        end
        cycle(1, 0, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
